mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register. Takes the ALU result (address), the rt value (store data) and the memory and write-back control bits.
- Runs one load or store per instruction on a ready-handshaked data-memory port, formats load data (byte/half/word, sign/zero extend) and stalls upstream until the access completes.
- Registers its results as the MEM/WB boundary, so it is the next sequential stage after EX/MEM.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported; byte-enable width is DATA_WIDTH/8.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- i_valid  in  1  EX/MEM slot holds a live instruction.
- i_mem_read  in  1  load.
- i_mem_write  in  1  store.
- i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- i_unsigned  in  1  zero-extend loads (lbu/lhu).
- i_addr  in  DATA_WIDTH  effective address (ALU result).
- i_wdata  in  DATA_WIDTH  store data (rt).
- i_reg_write  in  1  WB control.
- i_mem_to_reg  in  1  WB control.
- i_wreg  in  REG_ADDR_W  destination register.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  write strobe.
- dm_addr  out  DATA_WIDTH  word address: i_addr with [1:0] forced to 00.
- dm_be  out  4  byte enables.
- dm_wdata  out  DATA_WIDTH  lane-aligned store data.
- dm_ready  in  1  access complete; rdata valid this cycle.
- dm_rdata  in  DATA_WIDTH  read word.
- o_stall  out  1  hold PC/IF/ID/EX/EX-MEM. Combinational.
- o_valid, o_result, o_rdata, o_reg_write, o_mem_to_reg, o_wreg, o_misalign  out  1/DW/DW/1/1/REG_ADDR_W/1  MEM/WB outputs, registered.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - All outputs are 0: dm_req, dm_we, dm_addr, dm_be, dm_wdata and every o_* output.
  - Reset asserted mid-access drops dm_req immediately. The memory must tolerate an abandoned request.
- FSM states: IDLE, ACCESS.
- Classification:
  - mem_op = i_valid & (i_mem_read | i_mem_write).
  - If both read and write are set, write wins and the read is ignored.
- Misalignment:
  - A half access is misaligned when addr[0]=1.
  - A word access is misaligned when addr[1:0]≠00.
- IDLE, non-mem op or i_valid=0:
  - o_stall=0.
  - Next edge: o_valid<=i_valid, o_result<=i_addr, o_rdata<=0, WB controls passed through, o_misalign<=0.
  - Latency is 1 cycle.
- IDLE, misaligned mem op:
  - o_stall=0; no request is issued.
  - Next edge: o_valid<=1, o_misalign<=1, o_reg_write<=0, o_rdata<=0.
- IDLE, aligned mem op:
  - o_stall=1.
  - Next edge: dm_req<=1, dm_we/dm_addr/dm_be/dm_wdata loaded. The instruction is latched internally; it does not rely on EX/MEM staying stable. FSM goes to ACCESS.
  - Output regs take a bubble: o_valid<=0, o_reg_write<=0.
- ACCESS:
  - dm_req and all dm_* outputs are held stable until dm_ready=1.
  - o_stall = ~dm_ready.
  - Each edge with dm_ready=0: the output bubble is repeated.
  - Edge with dm_ready=1:
    - dm_req<=0, FSM goes to IDLE.
    - o_valid<=1, o_result<=latched addr, o_wreg and o_mem_to_reg from the latch.
    - o_rdata<=formatted load data; stores give o_rdata<=0 and o_reg_write<=0.
- Throughput: a zero-wait memory (dm_ready=1 in the first ACCESS cycle) gives 2 cycles per mem op. Back-to-back mem ops never overlap.
- Store lanes:
  - Byte: be = 0001 << addr[1:0], wdata = {4{rt[7:0]}}.
  - Half: be = 0011 << addr[1:0], wdata = {2{rt[15:0]}}.
  - Word: be = 1111, wdata = rt.
- Load formatting:
  - Select the lane by latched addr[1:0] (byte) or addr[1] (half).
  - Sign-extend unless i_unsigned=1, then zero-extend.
  - dm_be for loads is 1111.
- dm_ready while not in ACCESS is ignored.

Test Plan:
- Reset release, then add (i_valid=1, no mem op, i_addr=0x1234) -> next cycle o_valid=1, o_result=0x1234, o_stall never asserts, dm_req stays 0.
- lw from 0x100, dm_ready held 0 for 3 cycles, then dm_rdata=0xDEADBEEF -> o_stall high for 4 cycles, dm_addr=0x100 stable, o_rdata=0xDEADBEEF with o_valid=1 one edge after dm_ready.
- lb addr=0x203, then lbu addr=0x203, dm_rdata=0x80FFFF7F -> o_rdata=0xFFFFFF80, then 0x00000080.
- sh addr=0x302, rt=0x0000ABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, dm_addr=0x300, o_reg_write=0.
- lw addr=0x101 -> no dm_req, o_misalign=1, o_reg_write=0, no stall. Then sw addr=0x104 issues normally.
- rst driven low two cycles into ACCESS (dm_ready=0) -> dm_req=0 and o_stall=0 immediately without a clock edge; after release the FSM is in IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage issuing one load/store per instruction on a ready-handshaked data port.
// Load data is lane-selected and extended; results are registered as the MEM/WB boundary.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] i_wreg,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [DATA_WIDTH-1:0] dm_addr,
  output logic [3:0]            dm_be,
  output logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic                  dm_ready,
  input  logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_reg_write,
  output logic                  o_mem_to_reg,
  output logic [REG_ADDR_W-1:0] o_wreg,
  output logic                  o_misalign
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t r_state, w_next;
  logic                  r_we, r_unsigned, r_reg_write, r_mem_to_reg;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic w_mem_op, w_half, w_misalign, w_bad, w_start;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_sh, w_load;
  logic [7:0]            w_b;
  logic [15:0]           w_h;
  assign w_mem_op   = i_valid & (i_mem_read | i_mem_write);
  assign w_half     = ~i_size[1] & i_size[0];
  assign w_misalign = (w_half & i_addr[0]) | (i_size[1] & |i_addr[1:0]);
  assign w_bad      = w_mem_op & w_misalign;
  assign w_start    = (r_state == IDLE) & w_mem_op & ~w_misalign;
  // reset gates the stall so an abandoned access releases the pipeline at once
  assign o_stall    = rst & (w_start | ((r_state == ACCESS) & ~dm_ready));
  assign w_be    = i_size[1] ? 4'hF : (w_half ? 4'b0011 : 4'b0001) << i_addr[1:0];
  assign w_wdata = i_size[1] ? i_wdata : w_half ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
  assign w_sh    = dm_rdata >> {r_addr[1:0], 3'b000};
  assign w_b     = w_sh[7:0];
  assign w_h     = r_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  assign w_load  = r_size[1] ? dm_rdata
                 : r_size[0] ? {{16{~r_unsigned & w_h[15]}}, w_h}
                 : {{24{~r_unsigned & w_b[7]}}, w_b};
  always_comb begin
    w_next = r_state;
    w_next = w_start ? ACCESS : ((r_state == ACCESS) & dm_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_req <= 1'b0; dm_we <= 1'b0; dm_addr <= '0; dm_be <= '0; dm_wdata <= '0;
      o_valid <= 1'b0; o_result <= '0; o_rdata <= '0; o_reg_write <= 1'b0;
      o_mem_to_reg <= 1'b0; o_wreg <= '0; o_misalign <= 1'b0;
      r_we <= 1'b0; r_unsigned <= 1'b0; r_reg_write <= 1'b0; r_mem_to_reg <= 1'b0;
      r_size <= '0; r_addr <= '0; r_wreg <= '0;
    end else if (r_state == IDLE) begin
      if (w_start) begin
        dm_req       <= 1'b1;
        dm_we        <= i_mem_write;
        dm_addr      <= {i_addr[DATA_WIDTH-1:2], 2'b00};
        dm_be        <= i_mem_write ? w_be : 4'hF;
        dm_wdata     <= i_mem_write ? w_wdata : '0;
        r_we         <= i_mem_write;
        r_unsigned   <= i_unsigned;
        r_reg_write  <= i_reg_write;
        r_mem_to_reg <= i_mem_to_reg;
        r_size       <= i_size;
        r_addr       <= i_addr;
        r_wreg       <= i_wreg;
        o_valid      <= 1'b0;
        o_reg_write  <= 1'b0;
        o_misalign   <= 1'b0;
      end else begin
        o_valid      <= i_valid;
        o_result     <= i_addr;
        o_rdata      <= '0;
        o_reg_write  <= i_reg_write & ~w_bad;
        o_mem_to_reg <= i_mem_to_reg;
        o_wreg       <= i_wreg;
        o_misalign   <= w_bad;
      end
    end else if (dm_ready) begin
      dm_req       <= 1'b0;
      o_valid      <= 1'b1;
      o_result     <= r_addr;
      o_rdata      <= r_we ? '0 : w_load;
      o_reg_write  <= r_reg_write & ~r_we;
      o_mem_to_reg <= r_mem_to_reg;
      o_wreg       <= r_wreg;
      o_misalign   <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus with a write-back scoreboard checked by an independent monitor.
module tb_mem_access_unit;
  logic        clk = 0, rst = 1;
  logic        i_valid = 0, i_mem_read = 0, i_mem_write = 0, i_unsigned = 0;
  logic [1:0]  i_size = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, dm_rdata = 0;
  logic        i_reg_write = 0, i_mem_to_reg = 0, dm_ready = 0;
  logic [4:0]  i_wreg = 0;
  logic        dm_req, dm_we, o_stall, o_valid, o_reg_write, o_mem_to_reg, o_misalign;
  logic [31:0] dm_addr, dm_wdata, o_result, o_rdata;
  logic [3:0]  dm_be;
  logic [4:0]  o_wreg;
  int n_pass = 0, n_total = 0;
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] rd;
    logic        rw;
    logic        m2r;
    logic        mis;
    logic [4:0]  wreg;
  } wb_t;
  wb_t q[$];
  mem_access_unit dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .i_wreg(i_wreg),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .o_stall(o_stall), .o_valid(o_valid),
    .o_result(o_result), .o_rdata(o_rdata), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_wreg(o_wreg), .o_misalign(o_misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (rst && o_valid) begin
      if (q.size() == 0) chk("unexpected_o_valid", 32'd1, 32'd0);
      else begin
        wb_t e;
        e = q.pop_front();
        chk("wb_result", o_result, e.res);
        chk("wb_rdata", o_rdata, e.rd);
        chk("wb_reg_write", {31'd0, o_reg_write}, {31'd0, e.rw});
        chk("wb_mem_to_reg", {31'd0, o_mem_to_reg}, {31'd0, e.m2r});
        chk("wb_misalign", {31'd0, o_misalign}, {31'd0, e.mis});
        chk("wb_wreg", {27'd0, o_wreg}, {27'd0, e.wreg});
      end
    end
  end
  task automatic run_mem(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                         input logic [3:0] ebe, input logic [31:0] ewd, input int waits);
    i_valid = 1; i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
    i_addr = addr; i_wdata = wd;
    #1 chk("stall_on_issue", {31'd0, o_stall}, 32'd1);
    step();
    i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_addr = 32'hFFFF_FFFF; i_wdata = 0;
    for (int i = 0; i <= waits; i++) begin
      dm_ready = (i == waits);
      dm_rdata = (i == waits) ? rdv : 32'h5555_5555;
      #1;
      chk("dm_req_held", {31'd0, dm_req}, 32'd1);
      chk("dm_we", {31'd0, dm_we}, {31'd0, wr});
      chk("dm_addr", dm_addr, {addr[31:2], 2'b00});
      chk("dm_be", {28'd0, dm_be}, {28'd0, ebe});
      chk("dm_wdata", dm_wdata, ewd);
      chk("stall_access", {31'd0, o_stall}, (i == waits) ? 32'd0 : 32'd1);
      step();
    end
    dm_ready = 0;
    chk("dm_req_dropped", {31'd0, dm_req}, 32'd0);
  endtask
  initial begin
    #3 rst = 0;
    step(); step();
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_o_stall", {31'd0, o_stall}, 32'd0);
    rst = 1;
    step();
    // plain ALU op passes straight through
    i_valid = 1; i_addr = 32'h1234; i_reg_write = 1; i_wreg = 5'd3;
    q.push_back('{res: 32'h1234, rd: 0, rw: 1, m2r: 0, mis: 0, wreg: 5'd3});
    #1 chk("alu_no_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("alu_no_req", {31'd0, dm_req}, 32'd0);
    i_valid = 0;
    step();
    i_reg_write = 1; i_mem_to_reg = 1; i_wreg = 5'd5;
    q.push_back('{res: 32'h100, rd: 32'hDEADBEEF, rw: 1, m2r: 1, mis: 0, wreg: 5'd5});
    run_mem(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 4'hF, 32'd0, 3);
    i_wreg = 5'd6;
    q.push_back('{res: 32'h203, rd: 32'hFFFFFF80, rw: 1, m2r: 1, mis: 0, wreg: 5'd6});
    run_mem(1, 0, 2'b00, 0, 32'h203, 0, 32'h80FFFF7F, 4'hF, 32'd0, 0);
    i_wreg = 5'd7;
    q.push_back('{res: 32'h203, rd: 32'h00000080, rw: 1, m2r: 1, mis: 0, wreg: 5'd7});
    run_mem(1, 0, 2'b00, 1, 32'h203, 0, 32'h80FFFF7F, 4'hF, 32'd0, 0);
    i_wreg = 5'd8; i_mem_to_reg = 0;
    q.push_back('{res: 32'h302, rd: 32'd0, rw: 0, m2r: 0, mis: 0, wreg: 5'd8});
    run_mem(0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'h1111_1111, 4'b1100, 32'hABCDABCD, 1);
    // misaligned word load: trapped without touching memory
    i_valid = 1; i_mem_read = 1; i_size = 2'b10; i_addr = 32'h101; i_mem_to_reg = 1; i_wreg = 5'd9;
    q.push_back('{res: 32'h101, rd: 32'd0, rw: 0, m2r: 1, mis: 1, wreg: 5'd9});
    #1 chk("misalign_no_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("misalign_no_req", {31'd0, dm_req}, 32'd0);
    i_valid = 0; i_mem_read = 0; i_mem_to_reg = 0; i_wreg = 5'd10;
    q.push_back('{res: 32'h104, rd: 32'd0, rw: 0, m2r: 0, mis: 0, wreg: 5'd10});
    run_mem(0, 1, 2'b10, 0, 32'h104, 32'hCAFEF00D, 0, 4'hF, 32'hCAFEF00D, 0);
    // reset in the middle of an access abandons it
    i_valid = 1; i_mem_read = 1; i_size = 2'b10; i_addr = 32'h200; i_wreg = 5'd11;
    step();
    i_valid = 0; i_mem_read = 0;
    step();
    chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
    rst = 0;
    #1;
    chk("midrst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("midrst_stall", {31'd0, o_stall}, 32'd0);
    step();
    rst = 1;
    step();
    i_valid = 1; i_addr = 32'h55; i_reg_write = 1; i_wreg = 5'd12; dm_ready = 1;
    q.push_back('{res: 32'h55, rd: 0, rw: 1, m2r: 0, mis: 0, wreg: 5'd12});
    #1 chk("post_rst_idle_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("post_rst_no_req", {31'd0, dm_req}, 32'd0);
    i_valid = 0; dm_ready = 0;
    step(); step();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
